// File: rtl/fib_pair_serializer.sv
// Pair-in, word-out circular FIFO for the double-rate Fibonacci generator.
// Emitted words are checked on the fly against the modular sum of the previous two.
module fib_pair_serializer #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_num_i,
    input  logic [W-1:0] in_num2_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_num_o,
    output logic         err_o,
    output logic [15:0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [W-1:0]  p1_q, p1_d;
    logic [W-1:0]  p2_q, p2_d;
    logic [1:0]    seen_q, seen_d;
    logic          err_q, err_d;
    logic [15:0]   count_q, count_d;

    logic          push;
    logic          pop;
    logic [AW-1:0] wrPtrPlus1;
    logic [W-1:0]  expectedSum;

    // Ready depends only on registered occupancy so a whole pair always fits.
    assign in_ready_o  = (occ_q <= OW'(DEPTH - 2));
    assign out_valid_o = (occ_q != '0);
    assign out_num_o   = mem_q[rdPtr_q];
    assign err_o       = err_q;
    assign count_o     = count_q;

    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign wrPtrPlus1  = wrPtr_q + AW'(1);
    assign expectedSum = p1_q + p2_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        seen_d  = seen_q;
        err_d   = err_q;
        count_d = count_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(2);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(2);
            2'b01:   occ_d = occ_q - OW'(1);
            2'b11:   occ_d = occ_q + OW'(1);
            default: occ_d = occ_q;
        endcase

        // The checker only judges a word once two predecessors have been emitted.
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
            count_d = count_q + 16'd1;
            if (seen_q == 2'd2 && out_num_o != expectedSum) begin
                err_d = 1'b1;
            end
            p2_d = p1_q;
            p1_d = out_num_o;
            if (seen_q != 2'd2) begin
                seen_d = seen_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wrPtr_q]    <= in_num_i;
            mem_q[wrPtrPlus1] <= in_num2_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            seen_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed bench for fib_pair_serializer: reset, single pair, live Fibonacci
// stream, fill/back-pressure across pointer wrap, error injection, push+pop.
module tb_fib_pair_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_num_i;
    logic [15:0] in_num2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_num_o;
    logic        err_o;
    logic [15:0] count_o;

    int checks;
    int errors;

    fib_pair_serializer #(.W(16), .DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_num_i    (in_num_i),
        .in_num2_i   (in_num2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_num_o   (out_num_o),
        .err_o       (err_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        in_num_i    = '0;
        in_num2_i   = '0;
        out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Live double-rate generator with random back-pressure; 40 pairs, 80 words.
    task automatic applyStimulus();
        logic [15:0] srcA, srcB, expA, expB, nextA, word24;
        int pairsSent, popIdx;
        logic pushNow, popNow;
        srcA = 16'd1; srcB = 16'd1;
        expA = 16'd1; expB = 16'd1;
        pairsSent = 0; popIdx = 0; word24 = '0;
        for (int cyc = 0; cyc < 800 && popIdx < 80; cyc++) begin
            in_valid_i  = (pairsSent < 40);
            in_num_i    = srcA;
            in_num2_i   = srcB;
            out_ready_i = ($urandom_range(0, 1) == 1);
            #1;
            pushNow = in_valid_i && in_ready_o;
            popNow  = out_valid_o && out_ready_i;
            if (popNow) begin
                checkOutput("live_word", out_num_o, expA);
                if (popIdx == 24) word24 = out_num_o;
            end
            @(posedge clk);
            #1;
            if (pushNow) begin
                nextA = srcA + srcB;
                srcB  = nextA + srcB;
                srcA  = nextA;
                pairsSent++;
            end
            if (popNow) begin
                nextA = expB;
                expB  = expA + expB;
                expA  = nextA;
                popIdx++;
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        checkOutput("live_pops", popIdx, 80);
        checkOutput("live_count", count_o, 80);
        checkOutput("live_err", err_o, 0);
        checkOutput("live_wrap24", word24, 16'd9489);
    endtask

    initial begin
        int accepted, words;
        logic [15:0] expWord;
        checks = 0;
        errors = 0;

        // Reset state while held and after release.
        rst_n = 1'b0; in_valid_i = 1'b0; in_num_i = '0; in_num2_i = '0; out_ready_i = 1'b0;
        #2;
        checkOutput("rst_in_ready", in_ready_o, 1);
        checkOutput("rst_out_valid", out_valid_o, 0);
        checkOutput("rst_out_num", out_num_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_count", count_o, 0);
        applyReset();
        #1;
        checkOutput("rel_in_ready", in_ready_o, 1);
        checkOutput("rel_out_valid", out_valid_o, 0);

        // Single pair (1,1) drains in two cycles.
        in_valid_i = 1'b1; in_num_i = 16'd1; in_num2_i = 16'd1; out_ready_i = 1'b1;
        stepCycle();
        in_valid_i = 1'b0;
        checkOutput("single_v0", out_valid_o, 1);
        checkOutput("single_w0", out_num_o, 1);
        stepCycle();
        checkOutput("single_w1", out_num_o, 1);
        checkOutput("single_cnt1", count_o, 1);
        stepCycle();
        checkOutput("single_empty", out_valid_o, 0);
        checkOutput("single_cnt2", count_o, 2);
        checkOutput("single_err", err_o, 0);

        applyReset();
        applyStimulus();

        // Fill with no pops: only 4 of 6 pairs fit.
        applyReset();
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid_i = 1'b1;
            in_num_i   = 16'(10 + 2 * k);
            in_num2_i  = 16'(11 + 2 * k);
            #1;
            if (in_ready_o) accepted++;
            stepCycle();
        end
        in_valid_i = 1'b0;
        checkOutput("fill_accepted", accepted, 4);
        checkOutput("fill_ready_full", in_ready_o, 0);
        checkOutput("fill_head", out_num_o, 10);
        out_ready_i = 1'b1;
        stepCycle();
        checkOutput("fill_ready_occ7", in_ready_o, 0);
        checkOutput("fill_head11", out_num_o, 11);
        stepCycle();
        checkOutput("fill_ready_occ6", in_ready_o, 1);
        checkOutput("fill_head12", out_num_o, 12);
        in_valid_i = 1'b1; in_num_i = 16'd18; in_num2_i = 16'd19;
        stepCycle();
        in_valid_i = 1'b0;
        expWord = 16'd13;
        words = 0;
        for (int cyc = 0; cyc < 20 && out_valid_o; cyc++) begin
            checkOutput("wrap_word", out_num_o, expWord);
            expWord++;
            words++;
            stepCycle();
        end
        checkOutput("wrap_words", words, 7);
        checkOutput("wrap_count", count_o, 10);
        out_ready_i = 1'b0;

        // Error injection: 4 != 1+2 must latch err.
        applyReset();
        in_valid_i = 1'b1; in_num_i = 16'd1; in_num2_i = 16'd1;
        stepCycle();
        in_num_i = 16'd2; in_num2_i = 16'd4;
        stepCycle();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("inj_err_pre", err_o, 0);
        checkOutput("inj_head4", out_num_o, 4);
        stepCycle();
        checkOutput("inj_err_set", err_o, 1);
        in_valid_i = 1'b1; in_num_i = 16'd6; in_num2_i = 16'd10;
        stepCycle();
        in_valid_i = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("inj_err_sticky", err_o, 1);
        checkOutput("inj_count", count_o, 6);
        // Asynchronous reset mid-cycle, checked before the next edge.
        in_valid_i = 1'b1; in_num_i = 16'd7; in_num2_i = 16'd8;
        stepCycle();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_err", err_o, 0);
        checkOutput("async_count", count_o, 0);
        checkOutput("async_valid", out_valid_o, 0);
        applyReset();

        // Simultaneous push and pop at occupancy 3.
        in_valid_i = 1'b1; in_num_i = 16'd1; in_num2_i = 16'd1;
        stepCycle();
        in_num_i = 16'd2; in_num2_i = 16'd3;
        stepCycle();
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        stepCycle();
        in_valid_i = 1'b1; in_num_i = 16'd5; in_num2_i = 16'd8;
        stepCycle();
        in_valid_i = 1'b0;
        checkOutput("pp_ready", in_ready_o, 1);
        checkOutput("pp_head", out_num_o, 2);
        words = 0;
        for (int cyc = 0; cyc < 10 && out_valid_o; cyc++) begin
            case (words)
                0: checkOutput("pp_w0", out_num_o, 2);
                1: checkOutput("pp_w1", out_num_o, 3);
                2: checkOutput("pp_w2", out_num_o, 5);
                default: checkOutput("pp_w3", out_num_o, 8);
            endcase
            words++;
            stepCycle();
        end
        checkOutput("pp_occ4", words, 4);
        checkOutput("pp_err", err_o, 0);
        checkOutput("pp_count", count_o, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_pair_serializer.md
# fib_pair_serializer

Downstream stage for the double-rate Fibonacci generator. It accepts two 16-bit sequence words per cycle over a valid/ready handshake and buffers them in a small circular FIFO. It emits one word per cycle over a second valid/ready handshake. While emitting, it checks on the fly that every emitted word is the modular sum of the two words before it, and keeps a sticky error flag and a running word count.

## Interface
- `W`, 16, data width of every sequence word.
- `DEPTH`, 8, FIFO capacity in words; power of two, at least 4.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserting it (0) clears all state immediately.
- `in_valid`  in  1  upstream presents a word pair.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_num`  in  W  first (older) word of the pair.
- `in_num2`  in  W  second (newer) word of the pair.
- `out_valid`  out  1  `out_num` holds a valid word.
- `out_ready`  in  1  downstream accepts `out_num` this cycle.
- `out_num`  out  W  current head-of-FIFO word (show-ahead).
- `err`  out  1  sticky flag: a Fibonacci-property violation has been emitted.
- `count`  out  16  number of words emitted since reset, wraps modulo 2^16.

## Operation
- State:
  - `mem[DEPTH]` of W bits.
  - `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `occ`, the occupancy, log2(DEPTH)+1 bits, range 0..DEPTH.
  - Checker registers `p1` (last emitted word), `p2` (the word before it), `seen` (saturating count 0..2), `err`, and `count`.
- `in_ready` is 1 when DEPTH−occ ≥ 2. It is a function of registered state only; there is no combinational path from `out_ready` or `in_valid`.
- Push happens when `in_valid && in_ready`:
  - `mem[wr_ptr]` ← `in_num`.
  - `mem[wr_ptr+1 mod DEPTH]` ← `in_num2`.
  - `wr_ptr` += 2.
  - A pair is never split; a push is two words or nothing.
- `out_valid` is 1 when occ ≠ 0, and `out_num` = `mem[rd_ptr]`.
- Pop happens when `out_valid && out_ready`. It increments `rd_ptr` and `count` (wrap).
- Occupancy update on each edge: push only → occ+2; pop only → occ−1; push and pop together → occ+1; neither → unchanged.
- Checker, evaluated on each pop with x = `out_num`:
  - If `seen`=2 and x ≠ (p1+p2) mod 2^W, then `err` ← 1.
  - Then `p2` ← `p1`, `p1` ← x, and `seen` ← min(`seen`+1, 2).
  - The addition is W-bit with carry discarded, so a correctly wrapped sequence past 65535 does not flag.
  - `err` clears only on reset.
- Input words with `in_valid`=0 are ignored. `out_ready` while `out_valid`=0 has no effect.

## Timing
- Reset values, forced while `rst`=0:
  - `in_ready`=1, `out_valid`=0, `out_num`=0 (memory cleared), `err`=0, `count`=0.
  - All pointers, `occ`, `p1`, `p2` and `seen` = 0.
- Reset mid-operation discards all buffered words and the checker history. The first pair after reset release is treated as a fresh sequence start.
- Latency:
  - A pair accepted at edge N makes `in_num` visible on `out_num`, with `out_valid`=1, after edge N (zero-bubble when the FIFO was empty).
  - `in_num2` becomes the head after the edge on which `in_num` is popped.
- Throughput:
  - Output sustains 1 word/cycle.
  - Input sustains 1 pair every 2 cycles at steady state.
  - With `out_ready` held high, `in_ready` toggles accordingly once `occ` reaches DEPTH−1.
- Full condition: with DEPTH=8 and no pops, exactly 4 pairs are accepted; `in_ready` deasserts after the 4th.
  - With occ=7, `in_ready`=0 even if a pop occurs in the same cycle; the pop takes effect, and `in_ready` rises the next cycle.
- Empty condition: `out_valid`=0; a same-cycle push does not make data visible until the following cycle.
- `err` and `count` update on the edge of the pop that causes them and are visible the cycle after.

## Test plan
- Reset check: hold `rst`=0, then release. Required: `in_ready`=1, `out_valid`=0, `err`=0, `count`=0. Asserting `rst` asynchronously mid-cycle clears outputs without waiting for a clock edge.
- Single pair: push (1,1) with `out_ready`=1. Required: `out_num`=1 on the next two cycles, then `out_valid`=0, `count`=2, `err`=0.
- Live generator: connect a double-rate Fibonacci source and run 40 pairs with `out_ready` randomised. Required: the emitted stream is 1,1,2,3,5,…, correct modulo 2^16 past word 24 (46368+28657 wraps to 9489), `err`=0, and `count` equals the number of pops.
- Fill and back-pressure: hold `out_ready`=0 and offer 6 pairs. Required: only 4 accepted and `in_ready`=0 at occ=8. Then raise `out_ready`: `in_ready` returns to 1 when occ ≤ 6, and no word is lost or duplicated across pointer wrap.
- Error injection: push (1,1), (2,4). Required: `err`=1 the cycle after the 4th word (4 ≠ 1+2) pops. `err` stays 1 through subsequent correct words until reset.
- Simultaneous push/pop: at occ=3, push and pop in the same cycle. Required: occ=4, and head order is preserved.
